// File: rtl/ncl_mult_seq.sv
// Iterative shift-add WIDTH x WIDTH unsigned multiplier with NCL dual-rail I/O and Ki/Ko handshake.
// Define NCL_MULT_ILLEGAL_CHK_EN to flag (1,1) input rails on a sticky err output.
module ncl_mult_seq #(
    parameter int WIDTH = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   a_rail1,
    input  logic [WIDTH-1:0]   a_rail0,
    input  logic [WIDTH-1:0]   b_rail1,
    input  logic [WIDTH-1:0]   b_rail0,
    input  logic               Ki,
    output logic [2*WIDTH-1:0] p_rail1,
    output logic [2*WIDTH-1:0] p_rail0,
    output logic               Ko,
    output logic               err
);

    localparam int         PW       = 2 * WIDTH;
    localparam logic [4:0] LAST_CNT = 5'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        WAIT_KI,
        PRESENT,
        DRAIN
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [PW-1:0]   p1_q, p1_d;
    logic [PW-1:0]   p0_q, p0_d;
    logic            ko_q, ko_d;
    logic            null_seen_q, null_seen_d;

    logic in_complete;
    logic in_null;

    // A (1,1) bit has xor 0, so it can never count as complete DATA.
    assign in_complete = (&(a_rail1 ^ a_rail0)) && (&(b_rail1 ^ b_rail0));
    assign in_null     = ~|{a_rail1, a_rail0, b_rail1, b_rail0};

    always_comb begin
        state_d     = state_q;
        a_sh_d      = a_sh_q;
        b_d         = b_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        p1_d        = p1_q;
        p0_d        = p0_q;
        null_seen_d = null_seen_q;

        if (state_q != IDLE && in_null) begin
            null_seen_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (in_complete) begin
                    a_sh_d      = PW'(a_rail1);
                    b_d         = b_rail1;
                    acc_d       = '0;
                    cnt_d       = '0;
                    null_seen_d = 1'b0;
                    state_d     = CALC;
                end
            end
            CALC: begin
                // Multiplicand shifts left and multiplier right, so only bit 0 of B is ever inspected.
                if (b_q[0]) begin
                    acc_d = acc_q + a_sh_q;
                end
                a_sh_d = a_sh_q << 1;
                b_d    = b_q >> 1;
                cnt_d  = cnt_q + 5'd1;
                if (cnt_q == LAST_CNT) begin
                    state_d = WAIT_KI;
                end
            end
            WAIT_KI: begin
                if (Ki) begin
                    p1_d    = acc_q;
                    p0_d    = ~acc_q;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (!Ki) begin
                    p1_d    = '0;
                    p0_d    = '0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (null_seen_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ko_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_sh_q      <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            p1_q        <= '0;
            p0_q        <= '0;
            ko_q        <= 1'b1;
            null_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_sh_q      <= a_sh_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            p1_q        <= p1_d;
            p0_q        <= p0_d;
            ko_q        <= ko_d;
            null_seen_q <= null_seen_d;
        end
    end

    assign p_rail1 = p1_q;
    assign p_rail0 = p0_q;
    assign Ko      = ko_q;

`ifdef NCL_MULT_ILLEGAL_CHK_EN
    logic err_q, err_d;
    logic illegal;

    assign illegal = (|(a_rail1 & a_rail0)) || (|(b_rail1 & b_rail0));

    always_comb begin
        err_d = err_q | illegal;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
